// File: rtl/restoring_div_ctrl.sv
// -----------------------------------------------------------------------------
// restoring_div_ctrl
//
// Multi-cycle unsigned restoring divider with an IDLE/RUN/DONE control FSM.
// A division is accepted on start_i while idle. The divider then performs one
// restoring step per clock for `width` clocks, and pulses done_o for one cycle.
// quotient_o and remainder_o stay valid from done_o until the next accepted
// start.
//
// Optional feature (compile-time macro):
//   DIV_ZERO_DETECT_EN - when defined, a zero divisor is detected at accept
//                        time. The FSM goes straight to DONE with
//                        quotient = all ones, remainder = dividend and
//                        div0_o = 1. When undefined, div0_o is tied to 0 and
//                        a zero divisor runs through all iterations, which
//                        gives the same quotient and remainder.
//
// Ports:
//   clk_i        in   clock, all state on the rising edge
//   rst_i        in   asynchronous active-high reset
//   start_i      in   division request, sampled only in IDLE
//   dividend_i   in   [width-1:0] unsigned dividend, captured on accept
//   divisor_i    in   [width-1:0] unsigned divisor, captured on accept
//   busy_o       out  high while iterating (RUN)
//   done_o       out  one-cycle completion pulse (DONE)
//   quotient_o   out  [width-1:0] quotient
//   remainder_o  out  [width-1:0] remainder
//   div0_o       out  divide-by-zero flag
// -----------------------------------------------------------------------------

// n-bit subtractor with borrow-in/borrow-out: {cout_o, diff_o} = a_i - b_i - cin_i
module full_sub_wborrow_nbits #(
    parameter int n = 9
) (
    input  logic [n-1:0] a_i,
    input  logic [n-1:0] b_i,
    input  logic         cin_i,
    output logic [n-1:0] diff_o,
    output logic         cout_o
);
    logic [n:0] ext;

    // A negative result wraps into the extra MSB, which is the borrow out.
    assign ext    = {1'b0, a_i} - {1'b0, b_i} - {{n{1'b0}}, cin_i};
    assign diff_o = ext[n-1:0];
    assign cout_o = ext[n];
endmodule

module restoring_div_ctrl #(
    parameter int width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [width-1:0] dividend_i,
    input  logic [width-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [width-1:0] quotient_o,
    output logic [width-1:0] remainder_o,
    output logic             div0_o
);
    localparam int CNT_W = $clog2(width) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(width - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [width-1:0] dvd_sh;     // latched dividend, consumed MSB first
    logic [width-1:0] dsr;        // latched divisor
    logic [width-1:0] quo;
    logic [width-1:0] rem;
    logic [CNT_W-1:0] cnt;

    logic [width:0]   rem_shift;  // partial remainder after the left shift
    logic [width:0]   diff;
    logic             borrow;
    logic             take;
    logic             zero_hit;

    assign rem_shift = {rem, dvd_sh[width-1]};

    full_sub_wborrow_nbits #(
        .n (width + 1)
    ) u_sub (
        .a_i    (rem_shift),
        .b_i    ({1'b0, dsr}),
        .cin_i  (1'b0),
        .diff_o (diff),
        .cout_o (borrow)
    );

    // Without a borrow the difference is always below the divisor, so its top
    // bit is 0. Folding that bit in means an impossible out-of-range step
    // keeps the shifted remainder instead of silently truncating it.
    assign take = ~borrow & ~diff[width];

`ifdef DIV_ZERO_DETECT_EN
    logic div0;
    assign zero_hit = (divisor_i == '0);
    assign div0_o   = div0;
`else
    assign zero_hit = 1'b0;
    assign div0_o   = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and status outputs
    always_comb begin
        state_next = state;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = zero_hit ? DONE : RUN;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                if (cnt == LAST_ITER) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done_o     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture and the restoring iteration datapath
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dvd_sh <= '0;
            dsr    <= '0;
            quo    <= '0;
            rem    <= '0;
            cnt    <= '0;
`ifdef DIV_ZERO_DETECT_EN
            div0   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        dvd_sh <= dividend_i;
                        dsr    <= divisor_i;
                        quo    <= '0;
                        rem    <= '0;
                        cnt    <= '0;
`ifdef DIV_ZERO_DETECT_EN
                        div0   <= 1'b0;
                        if (zero_hit) begin
                            // Early exit with the natural restoring result.
                            quo  <= '1;
                            rem  <= dividend_i;
                            div0 <= 1'b1;
                        end
`endif
                    end
                end
                RUN: begin
                    dvd_sh <= dvd_sh << 1;
                    cnt    <= cnt + 1'b1;
                    if (take) begin
                        rem <= diff[width-1:0];
                        quo <= {quo[width-2:0], 1'b1};
                    end else begin
                        // Restore: keep the shifted remainder, which is
                        // below the divisor and so fits in width bits.
                        rem <= rem_shift[width-1:0];
                        quo <= {quo[width-2:0], 1'b0};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign quotient_o  = quo;
    assign remainder_o = rem;
endmodule

// File: tb/tb_restoring_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_restoring_div_ctrl
//
// Self-checking bench for restoring_div_ctrl (width = 8). Expected results
// come from plain integer division (/ and %) and from the timing rules of the
// control FSM: done_o appears `width` edges after the accepting edge, or right
// after it for a zero divisor when DIV_ZERO_DETECT_EN is defined.
// -----------------------------------------------------------------------------
module tb_restoring_div_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div0;

    int checks = 0;
    int errors = 0;

    restoring_div_ctrl #(.width(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .dividend_i  (dividend),
        .divisor_i   (divisor),
        .busy_o      (busy),
        .done_o      (done),
        .quotient_o  (quotient),
        .remainder_o (remainder),
        .div0_o      (div0)
    );

    always #5 clk = ~clk;

    // Runs one division. Inputs are driven and outputs sampled on falling
    // edges. Loop index i counts rising edges after the accepting edge E0.
    // ignore_at > 0 raises start with 50/5 just before edge E(ignore_at).
    // release_rst drops reset together with raising start.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int ignore_at, input bit release_rst,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic d0, output int done_at,
                          output int busy_cnt, output int done_cnt);
        q = '0; r = '0; d0 = 1'b0;
        done_at = -1; busy_cnt = 0; done_cnt = 0;
        @(negedge clk);
        if (release_rst) rst = 1'b0;
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0;
        dividend = W'($urandom); divisor = W'($urandom);
        for (int i = 0; i < 30; i++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = i; q = quotient; r = remainder; d0 = div0;
                end
            end
            if (ignore_at > 0 && i == ignore_at - 1) begin
                start = 1'b1; dividend = 8'd50; divisor = 8'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
        checks++; if (quotient !== '0) begin errors++; $display("FAIL reset_quotient: got %0d expected 0", quotient); end
        checks++; if (remainder !== '0) begin errors++; $display("FAIL reset_remainder: got %0d expected 0", remainder); end
        checks++; if (div0 !== 1'b0) begin errors++; $display("FAIL reset_div0: got %0b expected 0", div0); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [W-1:0] q, r; logic d0; int dat, bc, dc;
        run_op(8'd100, 8'd7, 0, 1'b0, q, r, d0, dat, bc, dc);
        checks++; if (dat !== W) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", dat, W); end
        checks++; if (q !== 8'd14) begin errors++; $display("FAIL basic_quotient: got %0d expected 14", q); end
        checks++; if (r !== 8'd2) begin errors++; $display("FAIL basic_remainder: got %0d expected 2", r); end
        checks++; if (d0 !== 1'b0) begin errors++; $display("FAIL basic_div0: got %0b expected 0", d0); end
        checks++; if (bc !== W) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected %0d", bc, W); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d expected 1", dc); end
        checks++; if (quotient !== 8'd14 || remainder !== 8'd2) begin
            errors++; $display("FAIL basic_hold: got %0d r %0d expected 14 r 2", quotient, remainder);
        end
    endtask

    task automatic test_extremes();
        logic [W-1:0] q, r; logic d0; int dat, bc, dc;
        run_op(8'd255, 8'd1, 0, 1'b0, q, r, d0, dat, bc, dc);
        checks++; if (q !== 8'd255 || r !== 8'd0) begin errors++; $display("FAIL div_255_1: got %0d r %0d expected 255 r 0", q, r); end
        run_op(8'd5, 8'd9, 0, 1'b0, q, r, d0, dat, bc, dc);
        checks++; if (q !== 8'd0 || r !== 8'd5) begin errors++; $display("FAIL div_5_9: got %0d r %0d expected 0 r 5", q, r); end
        checks++; if (dat !== W) begin errors++; $display("FAIL div_5_9_latency: got %0d expected %0d", dat, W); end
    endtask

    task automatic test_div_zero();
        logic [W-1:0] q, r; logic d0; int dat, bc, dc;
        int exp_dat, exp_bc; logic exp_d0;
`ifdef DIV_ZERO_DETECT_EN
        exp_dat = 0; exp_bc = 0; exp_d0 = 1'b1;
`else
        exp_dat = W; exp_bc = W; exp_d0 = 1'b0;
`endif
        run_op(8'd200, 8'd0, 0, 1'b0, q, r, d0, dat, bc, dc);
        checks++; if (q !== 8'd255 || r !== 8'd200) begin errors++; $display("FAIL div0_result: got %0d r %0d expected 255 r 200", q, r); end
        checks++; if (dat !== exp_dat) begin errors++; $display("FAIL div0_latency: got %0d expected %0d", dat, exp_dat); end
        checks++; if (bc !== exp_bc) begin errors++; $display("FAIL div0_busy_cycles: got %0d expected %0d", bc, exp_bc); end
        checks++; if (d0 !== exp_d0) begin errors++; $display("FAIL div0_flag: got %0b expected %0b", d0, exp_d0); end
        checks++; if (div0 !== exp_d0) begin errors++; $display("FAIL div0_flag_hold: got %0b expected %0b", div0, exp_d0); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL div0_done_pulses: got %0d expected 1", dc); end
    endtask

    task automatic test_start_ignored();
        logic [W-1:0] q, r; logic d0; int dat, bc, dc;
        run_op(8'd100, 8'd7, 3, 1'b0, q, r, d0, dat, bc, dc);
        checks++; if (q !== 8'd14 || r !== 8'd2) begin errors++; $display("FAIL ignore_result: got %0d r %0d expected 14 r 2", q, r); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL ignore_done_pulses: got %0d expected 1", dc); end
        checks++; if (bc !== W) begin errors++; $display("FAIL ignore_busy_cycles: got %0d expected %0d", bc, W); end
    endtask

    task automatic test_reset_midrun();
        logic [W-1:0] q, r; logic d0; int dat, bc, dc; int seen_done;
        @(negedge clk);
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrun_busy_before: got %0b expected 1", busy); end
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || div0 !== 1'b0) begin
            errors++; $display("FAIL midrun_async_flags: got busy %0b done %0b div0 %0b expected 0 0 0", busy, done, div0);
        end
        checks++; if (quotient !== '0 || remainder !== '0) begin
            errors++; $display("FAIL midrun_async_data: got %0d r %0d expected 0 r 0", quotient, remainder);
        end
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        checks++; if (seen_done !== 0) begin errors++; $display("FAIL midrun_no_done: got %0d pulses expected 0", seen_done); end
        run_op(8'd9, 8'd3, 0, 1'b1, q, r, d0, dat, bc, dc);
        checks++; if (q !== 8'd3 || r !== 8'd0) begin errors++; $display("FAIL after_reset_result: got %0d r %0d expected 3 r 0", q, r); end
        checks++; if (dat !== W) begin errors++; $display("FAIL after_reset_latency: got %0d expected %0d", dat, W); end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, q, r; logic d0; int dat, bc, dc;
        int exp_q, exp_r;
        for (int n = 0; n < 100; n++) begin
            a = W'($urandom_range(0, 255));
            b = W'($urandom_range(1, 255));
            exp_q = int'(a) / int'(b);
            exp_r = int'(a) % int'(b);
            run_op(a, b, 0, 1'b0, q, r, d0, dat, bc, dc);
            checks++; if (int'(q) !== exp_q || int'(r) !== exp_r) begin
                errors++; $display("FAIL rand_result %0d/%0d: got %0d r %0d expected %0d r %0d", a, b, q, r, exp_q, exp_r);
            end
            checks++; if (int'(q) * int'(b) + int'(r) !== int'(a) || r >= b) begin
                errors++; $display("FAIL rand_identity %0d/%0d: got q %0d r %0d expected q*d+r=dividend and r<d", a, b, q, r);
            end
            checks++; if (bc !== W || dat !== W || dc !== 1) begin
                errors++; $display("FAIL rand_timing %0d/%0d: got busy %0d done_at %0d pulses %0d expected %0d %0d 1", a, b, bc, dat, dc, W, W);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_div_zero();
        test_start_ignored();
        test_reset_midrun();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
